// File: rtl/start_fifo_srl_ctrl.sv
// SRL start-FIFO controller (occupancy, flags, read address); START_FIFO_SRL_CTRL_STATS_EN adds hwm/drop_cnt.
// Latency: shreg_we same cycle, flags/addr one edge later; backpressure via registered if_full_n/if_empty_n.
module start_fifo_srl_ctrl #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic                  if_empty_n,
  output logic                  shreg_we,
  output logic [ADDR_WIDTH-1:0] shreg_addr,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic [ADDR_WIDTH:0]   hwm,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_V  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   OCC_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                state_q;
  logic [ADDR_WIDTH:0]   occ_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  empty_n_q;
  logic                  full_n_q;
  logic                  push;
  logic                  pop;

  // Qualify with the registered flags only; reset gating keeps the SRL quiet while held in reset.
  assign push = if_write & if_write_ce & full_n_q & ap_rst_n;
  assign pop  = if_read & if_read_ce & empty_n_q & ap_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= S_EMPTY;
      occ_q     <= '0;
      addr_q    <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            occ_q     <= OCC_ONE;
            addr_q    <= '0;
            empty_n_q <= 1'b1;
            if (DEPTH == 1) begin
              state_q  <= S_FULL;
              full_n_q <= 1'b0;
            end else begin
              state_q  <= S_PARTIAL;
              full_n_q <= 1'b1;
            end
          end
        end
        S_PARTIAL: begin
          if (push && !pop) begin
            occ_q  <= occ_q + OCC_ONE;
            addr_q <= occ_q[ADDR_WIDTH-1:0];
            if (occ_q + OCC_ONE == DEPTH_V) begin
              state_q  <= S_FULL;
              full_n_q <= 1'b0;
            end
          end else if (pop && !push) begin
            occ_q <= occ_q - OCC_ONE;
            if (occ_q == OCC_ONE) begin
              addr_q    <= '0;
              state_q   <= S_EMPTY;
              empty_n_q <= 1'b0;
            end else begin
              addr_q <= addr_q - ADDR_ONE;
            end
          end
          // Push together with pop: the shift slides the next-oldest entry under addr_q.
        end
        S_FULL: begin
          if (pop) begin
            occ_q    <= occ_q - OCC_ONE;
            full_n_q <= 1'b1;
            if (DEPTH == 1) begin
              addr_q    <= '0;
              state_q   <= S_EMPTY;
              empty_n_q <= 1'b0;
            end else begin
              addr_q  <= addr_q - ADDR_ONE;
              state_q <= S_PARTIAL;
            end
          end
        end
        default: begin
          state_q   <= S_EMPTY;
          occ_q     <= '0;
          addr_q    <= '0;
          empty_n_q <= 1'b0;
          full_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign shreg_we   = push;
  assign shreg_addr = addr_q;
  assign occupancy  = occ_q;
  assign if_empty_n = empty_n_q;
  assign if_full_n  = full_n_q;

`ifdef START_FIFO_SRL_CTRL_STATS_EN
  logic [ADDR_WIDTH:0]  hwm_q;
  logic [CNT_WIDTH-1:0] drop_q;
  logic                 reject;

  // Both sides rejected in one cycle still count once.
  assign reject = (if_write & if_write_ce & ~full_n_q) | (if_read & if_read_ce & ~empty_n_q);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      hwm_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push && !pop && occ_q >= hwm_q) begin
        hwm_q <= occ_q + OCC_ONE;
      end
      if (reject && drop_q != {CNT_WIDTH{1'b1}}) begin
        drop_q <= drop_q + CNT_WIDTH'(1);
      end
    end
  end

  assign hwm      = hwm_q;
  assign drop_cnt = drop_q;
`else
  assign hwm      = '0;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Bench for start_fifo_srl_ctrl: DEPTH=4 instance against a queue model with a behavioural SRL, plus a DEPTH=1 instance.
module tb_start_fifo_srl_ctrl;
  localparam int D   = 4;
  localparam int AW  = 2;
  localparam int CW  = 16;
  localparam int CW1 = 8;

`ifdef START_FIFO_SRL_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wce = 1'b0, w = 1'b0, rce = 1'b0, r = 1'b0;
  logic [7:0]    wdat = '0;
  logic          full_n, empty_n, we;
  logic [AW-1:0] addr;
  logic [AW:0]   occ, hwm;
  logic [CW-1:0] drop;

  start_fifo_srl_ctrl #(.DEPTH(D), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_write_ce(wce), .if_write(w), .if_full_n(full_n),
    .if_read_ce(rce), .if_read(r), .if_empty_n(empty_n),
    .shreg_we(we), .shreg_addr(addr), .occupancy(occ), .hwm(hwm), .drop_cnt(drop)
  );

  logic           w1 = 1'b0, r1 = 1'b0;
  logic           full_n1, empty_n1, we1;
  logic [0:0]     addr1;
  logic [1:0]     occ1, hwm1;
  logic [CW1-1:0] drop1;

  start_fifo_srl_ctrl #(.DEPTH(1), .ADDR_WIDTH(1), .CNT_WIDTH(CW1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .if_write_ce(1'b1), .if_write(w1), .if_full_n(full_n1),
    .if_read_ce(1'b1), .if_read(r1), .if_empty_n(empty_n1),
    .shreg_we(we1), .shreg_addr(addr1), .occupancy(occ1), .hwm(hwm1), .drop_cnt(drop1)
  );

  // Behavioural SRL fed by the controller
  logic [7:0] srl [D];
  always @(posedge clk) begin
    if (we) begin
      for (int i = D - 1; i > 0; i--) srl[i] <= srl[i-1];
      srl[0] <= wdat;
    end
  end

  int checks = 0;
  int errors = 0;
  int q[$];
  int m_hwm = 0;
  int m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle on the DEPTH=4 instance: drive at negedge, check pre-edge view, update model at posedge.
  task automatic step(input logic iw, input logic iwce, input logic ir, input logic irce, input logic [7:0] d);
    bit ep, eo, rej;
    @(negedge clk);
    w = iw; wce = iwce; r = ir; rce = irce; wdat = d;
    #1;
    ep  = iw && iwce && (q.size() < D);
    eo  = ir && irce && (q.size() > 0);
    rej = (iw && iwce && q.size() == D) || (ir && irce && q.size() == 0);
    chk("occupancy", 32'(occ), q.size());
    chk("empty_n", 32'(empty_n), 32'(q.size() != 0));
    chk("full_n", 32'(full_n), 32'(q.size() != D));
    chk("shreg_addr", 32'(addr), (q.size() == 0) ? 0 : q.size() - 1);
    chk("shreg_we", 32'(we), 32'(ep));
    if (q.size() > 0) chk("dout", 32'(srl[addr]), q[0]);
    chk("hwm", 32'(hwm), STATS ? m_hwm : 0);
    chk("drop_cnt", 32'(drop), STATS ? m_drop : 0);
    @(posedge clk);
    if (eo) void'(q.pop_front());
    if (ep) q.push_back(d);
    if (q.size() > m_hwm) m_hwm = q.size();
    if (rej && m_drop < (1 << CW) - 1) m_drop++;
  endtask

  initial begin
    int exp_drop1;
    // Reset held with a write pending
    w = 1'b1; wce = 1'b1; w1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_full_n", 32'(full_n), 1);
      chk("rst_empty_n", 32'(empty_n), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_we1", 32'(we1), 0);
      chk("rst_occ", 32'(occ), 0);
      chk("rst_addr", 32'(addr), 0);
    end
    w = 1'b0; w1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with A..D, then a rejected write while full
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 8'hA1 + 8'(i));
    step(1, 1, 0, 0, 8'hEE);
    // Drain two, then five simultaneous push/pop at occupancy 2
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 8'hB0 + 8'(i));
    // Clock enables low on each side
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'hCC);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);
    // Drain fully, then reject a read on empty
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    step(1, 1, 1, 1, 8'h11);
    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step(1'($urandom), ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(3) != 0), 8'($urandom));
    step(0, 0, 0, 0, 8'h00);

    // DEPTH=1 instance
    @(negedge clk);
    w1 = 1'b1; r1 = 1'b0;
    #1 chk("d1_push_we", 32'(we1), 1);
    @(negedge clk);
    chk("d1_full_n", 32'(full_n1), 0);
    chk("d1_empty_n", 32'(empty_n1), 1);
    chk("d1_occ", 32'(occ1), 1);
    w1 = 1'b1; r1 = 1'b1;
    #1 chk("d1_rej_we", 32'(we1), 0);
    @(negedge clk);
    w1 = 1'b0; r1 = 1'b0;
    chk("d1_empty_after_pop", 32'(empty_n1), 0);
    chk("d1_full_n_after_pop", 32'(full_n1), 1);
    chk("d1_occ_after_pop", 32'(occ1), 0);
    chk("d1_addr", 32'(addr1), 0);
    chk("d1_hwm", 32'(hwm1), STATS ? 1 : 0);
    chk("d1_drop", 32'(drop1), STATS ? 1 : 0);
    // Fill then hammer with writes until the counter saturates
    exp_drop1 = 1;
    w1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_drop1 < (1 << CW1) - 1) exp_drop1++;
    end
    w1 = 1'b0;
    #1;
    chk("d1_drop_sat", 32'(drop1), STATS ? exp_drop1 : 0);
    chk("d1_full_hold", 32'(full_n1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
